load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Per-thread load/store unit; sits directly upstream of the memory controller as one of its NUM_CONSUMERS requesters.
//  Turns a decoded LDR/STR in the core's REQUEST stage into a valid/ready transaction on one consumer port.
//  Delivers read data to the register file in UPDATE and reports progress to the core scheduler.
//  Flags requests that exceed a latency budget.
// PARAMETERS
//  ADDR_BITS      8    memory address width; equals the controller's ADDR_BITS
//  DATA_BITS      16   data width; equals the controller's DATA_BITS
//  TIMEOUT_CYCLES 256  WAITING-cycle budget before lsu_error sets; 0 disables the check
// PORTS
//  clk                      in   1          system clock, all state on posedge
//  reset_n                  in   1          asynchronous, active-low reset
//  enable                   in   1          thread active; 0 = unit stays IDLE and issues nothing
//  core_state               in   3          core pipeline stage (core_state_t)
//  decoded_mem_read_enable  in   1          current instruction is LDR
//  decoded_mem_write_enable in   1          current instruction is STR
//  rs                       in   DATA_BITS  address operand
//  rt                       in   DATA_BITS  store data operand
//  mem_read_valid           out  1          read request to controller consumer port
//  mem_read_address         out  ADDR_BITS  read address
//  mem_read_ready           in   1          controller read done; data valid
//  mem_read_data            in   DATA_BITS  read data
//  mem_write_valid          out  1          write request
//  mem_write_address        out  ADDR_BITS  write address
//  mem_write_data           out  DATA_BITS  write data
//  mem_write_ready          in   1          controller write accepted
//  lsu_state                out  2          lsu_state_t: IDLE/REQUESTING/WAITING/DONE
//  lsu_out                  out  DATA_BITS  last loaded value
//  lsu_error                out  1          sticky latency-budget violation
// BEHAVIOUR
//  Reset (async, reset_n=0): lsu_state=IDLE; every valid, address, data, lsu_out, lsu_error and the timeout counter = 0.
//    The clear takes effect immediately, mid-transaction included.
//  enable=0: all state and outputs hold; no transitions.
//  IDLE -> REQUESTING: core_state==REQUEST and (read_en|write_en) and !mem_read_ready and !mem_write_ready.
//    The ready guard stops a stale controller RELAY handshake from being taken as a new transaction.
//    If read_en and write_en are both set, the read wins and the write is ignored.
//  REQUESTING (1 cycle): register valid=1 and address=rs[ADDR_BITS-1:0] (upper rs bits dropped).
//    For a store, also register mem_write_data=rt. Clear the timeout counter. Next state WAITING.
//  WAITING: valid, address and data are held stable until the matching ready is sampled 1.
//    Read: on mem_read_ready, mem_read_valid<=0 and lsu_out<=mem_read_data; next state DONE.
//    Write: on mem_write_ready, mem_write_valid<=0; next state DONE; lsu_out unchanged.
//    The counter increments each WAITING cycle and saturates at TIMEOUT_CYCLES.
//    When TIMEOUT_CYCLES!=0 and the counter reaches it, lsu_error<=1 (sticky until reset).
//    The transaction is never abandoned; the unit keeps waiting.
//  DONE: hold until core_state==UPDATE, then IDLE. lsu_out holds its value until the next load completes.
//  Latency: valid rises 2 edges after REQUEST is seen; DONE follows 1 edge after ready is sampled.
//  Valid drops on the same edge that moves the unit to DONE, so the controller leaves RELAY and drops ready a cycle later.
//  At most one outstanding transaction; read and write valids are never both 1.
// STRUCTURE
//  gpu_pkg: core_state_t (REQUEST=3'b011, UPDATE=3'b110, ...), lsu_state_t (IDLE=0, REQUESTING=1, WAITING=2, DONE=3).
//  Single always_ff with async reset plus a combinational next-state block; no sub-module.
//  Timeout counter width is $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  1 LDR: rs=16'h0012, REQUEST; ready after 3 cycles, data=16'hBEEF -> read_address=8'h12, read_valid high 4 cycles, lsu_out=16'hBEEF, DONE->IDLE on UPDATE.
//  2 STR: rs=16'h0105, rt=16'h00AA -> write_address=8'h05, write_data=16'h00AA held until ready; lsu_out unchanged.
//  3 Stale ready: mem_read_ready held 1 into the next REQUEST -> unit stays IDLE until ready=0, then issues.
//  4 Timeout: TIMEOUT_CYCLES=4, ready withheld 10 cycles -> lsu_error=1 after 4 WAITING cycles; completes normally on ready; error stays set.
//  5 Reset mid-WAITING: reset_n=0 asynchronously -> mem_read_valid=0 with no clock edge, lsu_state=IDLE.
//  6 Both enables set: read_en=write_en=1 -> only mem_read_valid asserts; enable=0 during REQUEST -> no request issued.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared pipeline and load/store state encodings for the GPU core slice.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Per-thread load/store unit: turns a decoded LDR/STR into one valid/ready
// transaction on a memory controller consumer port and returns load data.
import gpu_pkg::*;

module load_store_unit #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  core_state_t          core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output lsu_state_t           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    // A zero budget still needs a one-bit counter to keep the declarations legal.
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_t       next_state;
    logic             is_write;
    logic [CNT_W-1:0] timeout_count;
    logic [CNT_W-1:0] count_inc;
    logic             unused_rs_bits;

    assign unused_rs_bits = ^rs[DATA_BITS-1:ADDR_BITS];

    always_comb begin
        next_state = lsu_state;
        count_inc  = (timeout_count == CNT_MAX) ? timeout_count : timeout_count + CNT_W'(1);
        case (lsu_state)
            // Any ready still high belongs to the previous transaction's RELAY phase.
            LSU_IDLE: begin
                if (core_state == CORE_REQUEST
                    && (decoded_mem_read_enable || decoded_mem_write_enable)
                    && !mem_read_ready && !mem_write_ready)
                    next_state = LSU_REQUESTING;
            end
            LSU_REQUESTING: next_state = LSU_WAITING;
            LSU_WAITING: begin
                if (is_write ? mem_write_ready : mem_read_ready)
                    next_state = LSU_DONE;
            end
            LSU_DONE: begin
                if (core_state == CORE_UPDATE)
                    next_state = LSU_IDLE;
            end
            default: next_state = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lsu_state         <= LSU_IDLE;
            is_write          <= 1'b0;
            timeout_count     <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
            lsu_error         <= 1'b0;
        end else if (enable) begin
            lsu_state <= next_state;
            case (lsu_state)
                LSU_IDLE: begin
                    if (next_state == LSU_REQUESTING)
                        is_write <= !decoded_mem_read_enable;
                end
                LSU_REQUESTING: begin
                    timeout_count <= '0;
                    if (is_write) begin
                        mem_write_valid   <= 1'b1;
                        mem_write_address <= rs[ADDR_BITS-1:0];
                        mem_write_data    <= rt;
                    end else begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= rs[ADDR_BITS-1:0];
                    end
                end
                // The transaction is never abandoned; the budget only raises a sticky flag.
                LSU_WAITING: begin
                    timeout_count <= count_inc;
                    if (TIMEOUT_CYCLES != 0 && count_inc == CNT_MAX)
                        lsu_error <= 1'b1;
                    if (is_write && mem_write_ready)
                        mem_write_valid <= 1'b0;
                    if (!is_write && mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        lsu_out        <= mem_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
